// File: rtl/note_sequencer.sv
// Records {octave, note} entries on load key presses and replays them at a fixed note duration.
// Define NOTE_SEQ_LOOP_EN to make replay wrap to entry 0 until playback is pressed again.
module note_sequencer #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int NOTE_CYCLES = 25000000,
  parameter int TMR_W       = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        note,
  input  logic [1:0]        octave,
  input  logic              load_n,
  input  logic              playback,
  output logic [3:0]        out_note,
  output logic [1:0]        out_octave,
  output logic              note_valid,
  output logic              playing,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state, state_nx;
  logic [5:0]          mem [DEPTH];
  logic                prev_load_n, prev_playback;
  logic                load_evt, play_evt, last_entry;
  logic [ADDR_W-1:0]   wptr, wptr_nx, rptr, rptr_nx, rd_addr;
  logic [ADDR_W:0]     count_nx;
  logic                full_nx;
  logic [TMR_W-1:0]    timer, timer_nx;
  logic                we, ram_sel, zero_sel;

  assign load_evt   = prev_load_n & ~load_n;
  assign play_evt   = prev_playback & ~playback;
  assign last_entry = ({1'b0, rptr} == count - (ADDR_W+1)'(1));
  assign note_valid = (out_note != 4'd0);
  assign playing    = (state == PLAY);

  always_comb begin
    state_nx = state;
    wptr_nx  = wptr;
    rptr_nx  = rptr;
    count_nx = count;
    timer_nx = timer;
    rd_addr  = rptr;
    we       = 1'b0;
    ram_sel  = 1'b0;
    zero_sel = 1'b0;
    case (state)
      IDLE: begin
        if (load_evt && play_evt) begin
          count_nx = '0;
          wptr_nx  = '0;
        end else if (play_evt) begin
          if (count != '0) begin
            state_nx = PLAY;
            rptr_nx  = '0;
            rd_addr  = '0;
            ram_sel  = 1'b1;
            timer_nx = TMR_W'(NOTE_CYCLES - 1);
          end
        end else if (load_evt && note != 4'd0 && !full) begin
          we       = 1'b1;
          wptr_nx  = wptr + ADDR_W'(1);
          count_nx = count + (ADDR_W+1)'(1);
        end
      end
      PLAY: begin
        // Output register doubles as the RAM read register; rd_addr is the prefetched next pointer.
        ram_sel = 1'b1;
        if (play_evt) begin
          state_nx = IDLE;
          ram_sel  = 1'b0;
          zero_sel = 1'b1;
        end else if (timer == '0) begin
          if (last_entry) begin
`ifdef NOTE_SEQ_LOOP_EN
            rptr_nx  = '0;
            rd_addr  = '0;
            timer_nx = TMR_W'(NOTE_CYCLES - 1);
`else
            state_nx = IDLE;
            ram_sel  = 1'b0;
            zero_sel = 1'b1;
`endif
          end else begin
            rptr_nx  = rptr + ADDR_W'(1);
            rd_addr  = rptr + ADDR_W'(1);
            timer_nx = TMR_W'(NOTE_CYCLES - 1);
          end
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    full_nx = (count_nx == (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prev_load_n   <= 1'b1;
      prev_playback <= 1'b1;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      full          <= 1'b0;
      timer         <= '0;
      out_note      <= '0;
      out_octave    <= '0;
    end else begin
      state         <= state_nx;
      prev_load_n   <= load_n;
      prev_playback <= playback;
      wptr          <= wptr_nx;
      rptr          <= rptr_nx;
      count         <= count_nx;
      full          <= full_nx;
      timer         <= timer_nx;
      if (zero_sel) begin
        out_note   <= '0;
        out_octave <= '0;
      end else if (ram_sel) begin
        out_note   <= mem[rd_addr][3:0];
        out_octave <= mem[rd_addr][5:4];
      end else begin
        out_note   <= note;
        out_octave <= octave;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= {octave, note};
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: entry-list model checked every cycle plus hand-computed spot checks.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int NC    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] note = '0;
  logic [1:0] octave = '0;
  logic       load_n = 1'b1;
  logic       playback = 1'b1;
  logic [3:0] out_note;
  logic [1:0] out_octave;
  logic       note_valid, playing, full;
  logic [2:0] count;

  int total = 0;
  int bad = 0;

  note_sequencer #(.DEPTH(DEPTH), .ADDR_W(2), .NOTE_CYCLES(NC), .TMR_W(3)) dut (
    .clk(clk), .reset(reset), .note(note), .octave(octave), .load_n(load_n),
    .playback(playback), .out_note(out_note), .out_octave(out_octave),
    .note_valid(note_valid), .playing(playing), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: stored entries as a list, replay as (index, cycles remaining on this note).
  int m_note [DEPTH];
  int m_oct  [DEPTH];
  int m_count, m_idx, m_left, e_note, e_oct;
  bit m_play, m_pl, m_pp, m_ok = 1'b0;

  always @(posedge clk) begin
    bit le, pe;
    if (reset) begin
      m_count = 0; m_play = 0; m_idx = 0; m_left = 0;
      e_note = 0; e_oct = 0; m_pl = 1; m_pp = 1; m_ok = 1;
    end else begin
      le = m_pl && !load_n;
      pe = m_pp && !playback;
      if (!m_play) begin
        e_note = int'(note); e_oct = int'(octave);
        if (le && pe) m_count = 0;
        else if (pe) begin
          if (m_count > 0) begin
            m_play = 1; m_idx = 0; m_left = NC;
            e_note = m_note[0]; e_oct = m_oct[0];
          end
        end else if (le && note != 0 && m_count < DEPTH) begin
          m_note[m_count] = int'(note); m_oct[m_count] = int'(octave);
          m_count++;
        end
      end else if (pe) begin
        m_play = 0; e_note = 0; e_oct = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_idx == m_count - 1) begin
`ifdef NOTE_SEQ_LOOP_EN
            m_idx = 0; m_left = NC;
            e_note = m_note[0]; e_oct = m_oct[0];
`else
            m_play = 0; e_note = 0; e_oct = 0;
`endif
          end else begin
            m_idx++; m_left = NC;
            e_note = m_note[m_idx]; e_oct = m_oct[m_idx];
          end
        end
      end
      m_pl = load_n;
      m_pp = playback;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("out_note", out_note, e_note);
      check("out_octave", out_octave, e_oct);
      check("note_valid", note_valid, e_note != 0);
      check("playing", playing, m_play);
      check("count", count, m_count);
      check("full", full, m_count == DEPTH);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [3:0] n, input logic [1:0] o);
    note = n; octave = o; load_n = 1'b0;
    tick(1);
    load_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_play();
    playback = 1'b0;
    tick(1);
    playback = 1'b1;
    tick(1);
  endtask

  task automatic clear_all();
    load_n = 1'b0; playback = 1'b0;
    tick(1);
    load_n = 1'b1; playback = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_count", count, 0);
    check("rst_note", out_note, 0);
    check("rst_playing", playing, 0);
    check("rst_full", full, 0);

    pulse_load(4'd1, 2'd0);
    pulse_load(4'd5, 2'd2);
    pulse_load(4'd12, 2'd3);
    check("rec_count", count, 3);
    note = 4'd7; octave = 2'd1;
    tick(1);
    check("live_note", out_note, 7);

    playback = 1'b0;
    tick(1);
    check("p0_playing", playing, 1);
    check("p0_note", out_note, 1);
    check("p0_oct", out_octave, 0);
    playback = 1'b1;
    tick(4);
    check("p1_note", out_note, 5);
    check("p1_oct", out_octave, 2);
    tick(4);
    check("p2_note", out_note, 12);
    check("p2_oct", out_octave, 3);
    tick(4);
`ifdef NOTE_SEQ_LOOP_EN
    check("wrap_note", out_note, 1);
    check("wrap_playing", playing, 1);
    pulse_play();
`else
    check("end_note", out_note, 0);
    check("end_playing", playing, 0);
    tick(1);
    check("resume_live", out_note, 7);
`endif

    pulse_load(4'd0, 2'd2);
    check("zero_note_ignored", count, 3);

    load_n = 1'b0; playback = 1'b0;
    tick(1);
    check("clr_count", count, 0);
    check("clr_full", full, 0);
    check("clr_playing", playing, 0);
    load_n = 1'b1; playback = 1'b1;
    tick(1);

    pulse_play();
    check("empty_play", playing, 0);

    note = 4'd3; octave = 2'd1; load_n = 1'b0;
    tick(20);
    load_n = 1'b1;
    tick(1);
    check("held_load", count, 1);
    repeat (4) pulse_load(4'd3, 2'd1);
    check("full_count", count, 4);
    check("full_flag", full, 1);
    pulse_play();
    tick(20);
`ifdef NOTE_SEQ_LOOP_EN
    pulse_play();
`endif

    clear_all();
    pulse_load(4'd2, 2'd1);
    pulse_load(4'd4, 2'd2);
    playback = 1'b0;
    tick(1);
    playback = 1'b1;
    tick(5);
    check("second_entry", out_note, 4);
    playback = 1'b0;
    tick(1);
    check("abort_playing", playing, 0);
    check("abort_note", out_note, 0);
    playback = 1'b1;
    tick(2);
    playback = 1'b0;
    tick(1);
    check("restart_note", out_note, 2);
    check("restart_playing", playing, 1);
    playback = 1'b1;
    tick(2);

    reset = 1'b1;
    tick(1);
    check("midrst_note", out_note, 0);
    check("midrst_count", count, 0);
    check("midrst_playing", playing, 0);
    reset = 1'b0;
    tick(2);

    pulse_load(4'd9, 2'd0);
    pulse_load(4'd10, 2'd1);
    pulse_play();
    tick(20);
`ifdef NOTE_SEQ_LOOP_EN
    check("loop_playing", playing, 1);
    pulse_play();
    check("loop_stop", playing, 0);
`else
    check("single_pass_done", playing, 0);
`endif
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Downstream consumer of the keyboard converter's note, octave, load_n and playback outputs. Records a sequence of {octave, note} entries into a small RAM when the load key is pressed. Replays the sequence at a fixed note duration when the playback key is pressed. Passes live keystrokes through while idle. Its outputs drive the tone generator.

Parameters:
DEPTH, 32, number of stored note entries (power of two)
ADDR_W, 5, log2(DEPTH)
NOTE_CYCLES, 25000000, clock cycles each replayed note is held (0.5 s at 50 MHz)
TMR_W, 25, timer width; must satisfy 2^TMR_W > NOTE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
note  input  4  live note code; 0 = none, 1..12 = A..G#
octave  input  2  live octave select 0..3
load_n  input  1  active-low record request (level)
playback  input  1  active-low playback request (level)
out_note  output  4  note to tone generator; 0 = silence
out_octave  output  2  octave to tone generator
note_valid  output  1  high when out_note != 0
playing  output  1  high while in PLAY state
count  output  ADDR_W+1  number of stored entries, 0..DEPTH
full  output  1  high when count == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state = IDLE; write pointer, read pointer, count and timer = 0; out_note = 0; out_octave = 0; note_valid = 0; playing = 0; full = 0.
  - RAM contents are not cleared; count = 0 makes them unreachable.
- Edge detection: load_n and playback are registered once (prev copies reset to 1).
  - load_evt = prev_load_n & ~load_n.
  - play_evt = prev_playback & ~playback.
  - Held levels never re-trigger; only 1 -> 0 transitions count as events.
- States: IDLE, PLAY.
- IDLE:
  - out_note and out_octave register the live note and octave inputs (1-cycle latency).
  - note_valid = (registered note != 0).
- Event priority in IDLE: load_evt and play_evt in the same cycle is a clear.
  - count, write pointer and full go to 0; nothing is written; no playback starts.
- load_evt alone in IDLE:
  - If note != 0 and count < DEPTH: write {octave, note} at the write pointer; write pointer +1; count +1.
  - If note == 0: the event is ignored.
  - If full: the event is dropped and count is unchanged.
- play_evt alone in IDLE:
  - If count == 0: ignored; stay in IDLE.
  - Otherwise, on the next cycle: enter PLAY; read pointer = 0; out_note/out_octave = entry 0; timer = NOTE_CYCLES-1.
- PLAY:
  - playing = 1 and outputs hold the current entry; the timer decrements every cycle.
  - When the timer reaches 0:
    - If read pointer == count-1: go to IDLE on the next cycle; out_note = 0 for that cycle, after which live passthrough resumes.
    - Otherwise: read pointer +1; load the next entry; reload the timer.
  - Each entry is driven for exactly NOTE_CYCLES cycles.
- play_evt during PLAY aborts: next cycle the block is in IDLE, out_note = 0, playing = 0.
- load_evt during PLAY is ignored; recorded entries are never modified during PLAY.
- reset during PLAY: all registers return to reset values on the next edge; count = 0.
- RAM: DEPTH x 6 bits, synchronous write, registered read; the read address is prefetched so there are no bubbles between entries.
- full = (count == DEPTH) and is registered together with count.

Optional Feature:
- Macro: NOTE_SEQ_LOOP_EN.
- When defined: after the last entry (timer == 0, read pointer == count-1), the read pointer wraps to 0 and replay continues with no gap. Only play_evt or reset leaves PLAY.
- When undefined: a single pass, then return to IDLE as described above.

Test Plan:
- Bench setup: DEPTH=4, NOTE_CYCLES=4.
- Record and replay: record notes 1/oct0, 5/oct2, 12/oct3 via load_n pulses, then pulse playback -> count=3. out_note sequence is 1,5,12, each for exactly 4 cycles, with out_octave 0,2,3. playing high for 12 cycles, then out_note=0 for one cycle, then IDLE.
- Full: five load pulses with note=3 -> count stops at 4, full=1. The fifth pulse causes no write; replay shows four entries of 3.
- Ignore cases: load pulse with note=0 -> count unchanged. Holding load_n low for 20 cycles -> exactly one write. playback with count=0 -> playing stays 0.
- Abort: playback pulse during the second replayed note -> next cycle playing=0, out_note=0. A later playback restarts from entry 0.
- Clear: load_n and playback fall on the same cycle with count=3 -> count=0, full=0, playing=0.
- Reset mid-PLAY: assert reset during replay -> next edge: all outputs 0, count=0. With NOTE_SEQ_LOOP_EN, 2 entries replay as 4 cycles + 4 cycles, repeating until playback is pulsed.
